// File: rtl/scu_dsp_dma_port.sv
// scu_dsp_dma_port
//   SCU-side responder for the DSP DMA initiator. Holds the DSP read/write
//   word-address registers RA0/WA0 (loaded from the DSP D1 bus by strobe) and
//   turns every DSP DMA word request into one external bus transaction.
//   Signals DMA_END after the word flagged DMA_LAST has been acknowledged.
//
// Ports
//   CLK, RST_N          system clock, async active-low reset
//   RES_N               synchronous soft reset, active low
//   CE_R                DSP rising-phase clock enable (qualifies DSP handshakes)
//   DSO, RA0W, WA0W     D1 bus value and RA0/WA0 load strobes
//   DMA_REQ/RUN/WE/LAST DSP word request, DMA active, direction, final word
//   DMA_ADD             address step code (0 -> 0, n -> 1<<(n-1) words)
//   DMA_DO, DMA_DI      write data from DSP, read data to DSP
//   DMA_ACK, DMA_END    word serviced, transfer complete
//   BUS_*               external bus request/ack, byte address, data, write
//   RA0_Q, WA0_Q        current address register values
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a CE_R-qualified DSP word request
// BUS   | bus transaction outstanding, request/address/data held
// ACKW  | DMA_ACK high until the next CE_R edge, address advances there
// FIN   | DMA_END high for one full CE_R period
module scu_dsp_dma_port #(
  parameter int ADDR_W = 25
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RES_N,
  input  logic              CE_R,
  input  logic [31:0]       DSO,
  input  logic              RA0W,
  input  logic              WA0W,
  input  logic              DMA_REQ,
  input  logic              DMA_RUN,
  input  logic              DMA_WE,
  input  logic              DMA_LAST,
  input  logic [2:0]        DMA_ADD,
  input  logic [31:0]       DMA_DO,
  output logic [31:0]       DMA_DI,
  output logic              DMA_ACK,
  output logic              DMA_END,
  output logic [ADDR_W+1:0] BUS_ADDR,
  output logic [31:0]       BUS_DO,
  output logic              BUS_WE,
  output logic              BUS_REQ,
  input  logic              BUS_ACK,
  input  logic [31:0]       BUS_DI,
  output logic [ADDR_W-1:0] RA0_Q,
  output logic [ADDR_W-1:0] WA0_Q
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_ACKW, S_FIN} state_t;

  state_t            state_q, state_d;
  logic              dir_q;            // 1 = write (DSP -> bus)
  logic [ADDR_W-1:0] ra0_q, wa0_q;
  logic [ADDR_W-1:0] step;
  logic              start, bus_done, ack_done;
  logic              unused_dso;

  assign unused_dso = ^DSO[31:ADDR_W];

  assign start    = (state_q == S_IDLE) && CE_R && DMA_REQ && DMA_RUN && !DMA_ACK;
  assign bus_done = (state_q == S_BUS) && BUS_ACK;
  assign ack_done = (state_q == S_ACKW) && CE_R;

  assign step = (DMA_ADD == 3'd0) ? '0 : (ADDR_W'(1) << (DMA_ADD - 3'd1));

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      state_q <= S_IDLE;
    else if (!RES_N) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic; DMA_LAST is taken live at the CE_R edge that ends ACKW
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)   state_d = S_BUS;
      S_BUS:   if (BUS_ACK) state_d = S_ACKW;
      S_ACKW:  if (CE_R)    state_d = DMA_LAST ? S_FIN : S_IDLE;
      S_FIN:   if (CE_R)    state_d = S_IDLE;
      default:              state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decode directly from state
  always_comb begin
    BUS_REQ = (state_q == S_BUS);
    DMA_ACK = (state_q == S_ACKW);
    DMA_END = (state_q == S_FIN);
  end

  // Datapath: address registers, bus request payload, read data
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ra0_q    <= '0;
      wa0_q    <= '0;
      dir_q    <= 1'b0;
      BUS_ADDR <= '0;
      BUS_DO   <= '0;
      DMA_DI   <= '0;
    end else if (!RES_N) begin
      ra0_q    <= '0;
      wa0_q    <= '0;
      dir_q    <= 1'b0;
      BUS_ADDR <= '0;
      BUS_DO   <= '0;
      DMA_DI   <= '0;
    end else begin
      if (start) begin
        dir_q    <= DMA_WE;
        BUS_ADDR <= {(DMA_WE ? wa0_q : ra0_q), 2'b00};
        BUS_DO   <= DMA_DO;
      end
      if (bus_done && !dir_q)
        DMA_DI <= BUS_DI;
      // A load strobe takes priority over the post-word increment.
      if (RA0W)
        ra0_q <= DSO[ADDR_W-1:0];
      else if (ack_done && !dir_q)
        ra0_q <= ra0_q + step;
      if (WA0W)
        wa0_q <= DSO[ADDR_W-1:0];
      else if (ack_done && dir_q)
        wa0_q <= wa0_q + step;
    end
  end

  assign BUS_WE = dir_q;
  assign RA0_Q  = ra0_q;
  assign WA0_Q  = wa0_q;

endmodule

// File: doc/scu_dsp_dma_port.md
Name: scu_dsp_dma_port

Overview:
SCU-side responder for the DSP DMA initiator. It holds the DSP read/write address registers RA0 and WA0, which are loaded from the DSP D1 bus by strobe. It services each DSP DMA word request (DMA_REQ/DMA_ACK) with one external bus transaction. When the DSP's last word completes, it signals DMA_END. It sits between the DSP core and the SCU A/B-bus/work-RAM arbiter.

Parameters:
ADDR_W, 25, width of RA0/WA0 word-address registers; bus byte address is {reg, 2'b00}.

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
RES_N  in  1  synchronous soft reset, active low
CE_R  in  1  DSP rising-phase clock enable; all DSP-facing handshakes are evaluated on it
DSO  in  32  DSP D1 bus value
RA0W  in  1  load RA0 from DSO[ADDR_W-1:0] (CE-qualified pulse)
WA0W  in  1  load WA0 from DSO[ADDR_W-1:0]
DMA_REQ  in  1  DSP requests one word
DMA_RUN  in  1  DSP DMA active (T0)
DMA_WE  in  1  direction: 0 = bus→DSP (read at RA0), 1 = DSP→bus (write at WA0)
DMA_LAST  in  1  current word is the final one
DMA_ADD  in  3  address step: 0 → 0 words, n>0 → 1<<(n-1) words
DMA_DO  in  32  write data from DSP
DMA_DI  out  32  read data to DSP
DMA_ACK  out  1  word serviced
DMA_END  out  1  transfer complete; DSP detects the falling edge
BUS_ADDR  out  ADDR_W+2  byte address
BUS_DO  out  32  write data
BUS_WE  out  1  write strobe qualifier
BUS_REQ  out  1  bus request
BUS_ACK  in  1  bus acknowledge
BUS_DI  in  32  bus read data
RA0_Q  out  ADDR_W  current RA0
WA0_Q  out  ADDR_W  current WA0

Behaviour:
- Reset (RST_N low, or RES_N low at any CLK edge): state=IDLE.
  - RA0, WA0, DMA_DI, BUS_DO, BUS_ADDR = 0.
  - DMA_ACK, DMA_END, BUS_REQ, BUS_WE = 0.
  - Latched LAST and direction are cleared.
  - A mid-transfer reset drops BUS_REQ on the next edge with no completion signalling.
- States: IDLE, BUS, ACKW, FIN.
- IDLE: on CE_R with DMA_REQ && DMA_RUN && !DMA_ACK, latch the following and go to BUS with BUS_REQ=1:
  - DMA_WE into the direction latch; BUS_WE=DMA_WE.
  - BUS_ADDR = {DMA_WE ? WA0 : RA0, 2'b00}.
  - BUS_DO = DMA_DO.
- BUS: BUS_REQ, BUS_ADDR, BUS_DO and BUS_WE are held stable. BUS_ACK is sampled every CLK, not CE-gated. On BUS_ACK:
  - BUS_REQ=0.
  - If read, DMA_DI<=BUS_DI.
  - DMA_ACK<=1; go to ACKW.
  - There is no timeout.
- ACKW: DMA_ACK stays high until the next CE_R edge, so the DSP sees exactly one CE_R with DMA_ACK=1. At that edge:
  - DMA_ACK<=0.
  - The active address register (RA0 if read, WA0 if write) advances by the DMA_ADD step, wrapping mod 2^ADDR_W.
  - If DMA_LAST was high at that same edge, DMA_END<=1 and go to FIN; else go to IDLE.
- FIN: DMA_END is held for exactly one full CE_R period (cleared on the next CE_R edge), then go to IDLE. New requests are ignored in FIN.
- DMA_DI holds its last value between words.
- RA0W/WA0W:
  - Accepted in any state.
  - A load coinciding with an increment of the same register wins (the load value is taken, no increment).
  - A load during BUS does not change the BUS_ADDR already issued.
- DMA_RUN falling while in BUS: the bus cycle completes; DMA_ACK is still pulsed; no DMA_END unless DMA_LAST.
- Latency per word: 1 CE_R (request sample), plus bus wait, plus 1 CE_R (ack). Minimum 2 CE_R periods per word.

Test Plan:
- Read burst: RA0W with DSO=0x0000100, DMA_ADD=1, DMA_WE=0, bus returns 0xA0,0xA1,0xA2 for 3 words, DMA_LAST on the 3rd -> BUS_ADDR 0x400,0x404,0x408; DMA_DI matches each; exactly 3 single-CE_R DMA_ACK pulses; RA0_Q=0x103; one DMA_END pulse, then IDLE.
- Write with step: WA0W DSO=0x10, DMA_ADD=3, DMA_WE=1, DMA_DO=0xDEADBEEF, 2 words -> BUS_WE=1; BUS_ADDR 0x40 then 0x50; BUS_DO=0xDEADBEEF; WA0_Q=0x18; RA0 unchanged.
- Bus stall: BUS_ACK delayed 20 CLKs -> BUS_REQ/BUS_ADDR/BUS_DO stable throughout; DMA_ACK stays low until BUS_ACK is seen.
- Wrap and step 0: RA0=0x1FFFFFF, DMA_ADD=1 -> RA0=0 after 1 word; with DMA_ADD=0, RA0 unchanged across 4 words.
- Collision: RA0W DSO=0x55 on the same CE_R as the ACKW increment of RA0 -> RA0_Q=0x55.
- Reset mid-operation: RES_N low while in BUS -> BUS_REQ=0 and DMA_ACK=0 next edge, RA0/WA0=0, no DMA_END; the following request is serviced normally.
